// File: rtl/stream_take_arbiter_pkg.sv
// Shared definitions for the stream take arbiter: FSM states, default widths
// and small index helpers.
package stream_take_arbiter_pkg;

  // Payload width alias for the stream/int element.
  localparam int unsigned INT_N    = 32;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_CW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Successor of i in a ring of n slots.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/stream_take_arbiter_if.sv
// Request, upstream stream and per-requester output bundle of the stream take arbiter.
// master = requesters/producer side, slave = arbiter side.
interface stream_take_arbiter_if
  import stream_take_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW,
  parameter int unsigned DW   = INT_N
) ();

  localparam int unsigned IW = idx_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_count;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      sIn;
  logic               sIn_valid;
  logic               sIn_ready;
  logic [DW-1:0]      dOut;
  logic [NREQ-1:0]    dOut_valid;
  logic [NREQ-1:0]    dOut_ready;
  logic [IW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_count, sIn, sIn_valid, dOut_ready,
    input  req_ready, sIn_ready, dOut, dOut_valid, grant_id, busy
  );

  modport slave (
    input  req_valid, req_count, sIn, sIn_valid, dOut_ready,
    output req_ready, sIn_ready, dOut, dOut_valid, grant_id, busy
  );

endinterface

// File: rtl/stream_take_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of req at or above ptr, wrapping to 0.
module stream_take_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_take_arbiter.sv
// Round-robin arbiter handing one upstream stream to NREQ burst consumers.
// Optional STREAM_ARB_PRIO_EN: requester 0 gets strict priority at arbitration.
module stream_take_arbiter
  import stream_take_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW,
  parameter int unsigned DW   = INT_N
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_take_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_w(NREQ);

`ifdef STREAM_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            full_q, full_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            busy_q, busy_d;

  logic [CW-1:0]   cnt_arr [NREQ];
  logic [NREQ-1:0] pick_req;
  logic            pick_found, win_found;
  logic [IW-1:0]   pick_idx, win_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] req_ready_c;
  logic            sin_ready_c;
  logic            ld, unld;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    assign cnt_arr[gi] = bus.req_count[gi*CW +: CW];
  end

  // Under priority, requester 0 is taken out of the rotation and checked first.
  assign pick_req = PRIO_EN ? (bus.req_valid & ~NREQ'(1)) : bus.req_valid;

  stream_take_arbiter_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    win_found = pick_found;
    win_idx   = pick_idx;
    if (PRIO_EN && bus.req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
  end

  // A priority grant of requester 0 leaves the rotation where it was.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g, input logic [IW-1:0] cur);
    if (PRIO_EN && g == '0) return cur;
    return IW'(wrap_inc(32'(g), NREQ));
  endfunction

  assign gnt_oh = NREQ'(1) << gnt_q;

  // Next-state, counter, output register and handshake logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    rem_d       = rem_q;
    full_d      = full_q;
    dout_d      = dout_q;
    req_ready_c = '0;
    sin_ready_c = 1'b0;
    ld          = 1'b0;
    unld        = full_q & |(bus.dOut_ready & gnt_oh);

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready_c = NREQ'(1) << win_idx;
          gnt_d       = win_idx;
          rem_d       = cnt_arr[win_idx];
          if (cnt_arr[win_idx] == '0) rr_d = rr_next(win_idx, rr_q);
          else                        state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        sin_ready_c = !full_q | |(bus.dOut_ready & gnt_oh);
        ld          = sin_ready_c & bus.sIn_valid;
        if (ld) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (unld) begin
          rr_d    = rr_next(gnt_q, rr_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load wins over unload so a same-cycle swap keeps the register full.
    if (ld) begin
      full_d = 1'b1;
      dout_d = bus.sIn;
    end else if (unld) begin
      full_d = 1'b0;
    end

    // Nothing is accepted from requesters or upstream during reset.
    if (rst) begin
      req_ready_c = '0;
      sin_ready_c = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE) | full_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      rem_q   <= '0;
      full_q  <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      full_q  <= full_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.sIn_ready  = sin_ready_c;
  assign bus.dOut       = dout_q;
  assign bus.dOut_valid = full_q ? gnt_oh : '0;
  assign bus.grant_id   = gnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_stream_take_arbiter.sv
// Self-checking bench for stream_take_arbiter: directed scenarios plus random
// bursts against a transaction-level reference model.
module tb_stream_take_arbiter;
  import stream_take_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int DW   = 32;

`ifdef STREAM_ARB_PRIO_EN
  localparam bit PRIO   = 1'b1;
  localparam int EXP_T6 = 0;
`else
  localparam bit PRIO   = 1'b0;
  localparam int EXP_T6 = 3;
`endif

  logic clk = 1'b0;
  logic rst;

  stream_take_arbiter_if #(.NREQ(NREQ), .CW(CW), .DW(DW)) bus ();

  stream_take_arbiter #(.NREQ(NREQ), .CW(CW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0] mask;
  logic [CW-1:0]   cnts [NREQ];
  logic [DW-1:0]   data_base;
  logic [NREQ-1:0] nreq;
  int rr_m, last_g, grant_cyc, prev_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_req();
    bus.req_valid = mask;
    for (int i = 0; i < NREQ; i++) bus.req_count[i*CW +: CW] = cnts[i];
  endtask

  // Reference arbitration: who wins given pending requests and rotation start.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int rr);
    if (PRIO && m[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
      if (PRIO && i == 0) continue;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic reset_mid_burst();
    rst = 1'b1;
    bus.req_valid  = '1;
    bus.sIn_valid  = 1'b1;
    bus.dOut_ready = '1;
    @(negedge clk);
    chk("rst_sin_ready", 64'(bus.sIn_ready), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    next_cycle();
    rst  = 1'b0;
    mask = '0;
    apply_req();
    @(negedge clk);
    chk("post_rst_dout_valid", 64'(bus.dOut_valid), 64'd0);
    chk("post_rst_dout", 64'(bus.dOut), 64'd0);
    chk("post_rst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    chk("post_rst_sin_ready", 64'(bus.sIn_ready), 64'd0);
    rr_m = 0;
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      chk("post_rst_no_valid", 64'(bus.dOut_valid), 64'd0);
    end
  endtask

  // One arbitration plus the resulting burst, checked against the model.
  task automatic run_burst(input bit full_rate, input int bp_in, input int abort_after);
    int g, c, acc, del, occ, bp;
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   sq [$];
    logic            exp_rdy;
    bp = bp_in;
    next_cycle();
    bus.sIn_valid  = 1'b1;
    bus.sIn        = DW'($urandom);
    bus.dOut_ready = full_rate ? '1 : NREQ'($urandom);
    apply_req();
    @(negedge clk);
    g  = model_pick(mask, rr_m);
    oh = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(oh));
    chk("idle_sin_ready", 64'(bus.sIn_ready), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_dout_valid", 64'(bus.dOut_valid), 64'd0);
    if (g < 0) return;
    prev_cyc  = grant_cyc;
    grant_cyc = cyc;
    last_g    = g;
    c         = int'(cnts[g]);
    mask[g]   = 1'b0;
    if (!(PRIO && g == 0)) rr_m = (g + 1) % NREQ;
    acc = 0;
    del = 0;
    for (int n = 0; del < c; n++) begin
      if (n > 400) begin
        checks++;
        errors++;
        $error("FAIL burst_timeout observed=%0d delivered expected=%0d", del, c);
        return;
      end
      next_cycle();
      if (abort_after > 0 && acc == abort_after) begin
        reset_mid_burst();
        return;
      end
      bus.sIn_valid  = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.sIn        = full_rate ? data_base + DW'(acc) : DW'($urandom);
      bus.dOut_ready = (bp > 0) ? '0 : (full_rate ? '1 : NREQ'($urandom));
      bp--;
      if (!full_rate && $urandom_range(0, 3) == 0) begin
        nreq = NREQ'($urandom) & ~mask;
        for (int i = 0; i < NREQ; i++) if (nreq[i]) cnts[i] = CW'($urandom);
        mask = mask | nreq;
      end
      apply_req();
      @(negedge clk);
      occ = acc - del;
      if (n == 0) begin
        chk("grant_id", 64'(bus.grant_id), 64'(g));
        chk("burst_busy", 64'(bus.busy), 64'd1);
      end
      chk("dout_valid", 64'(bus.dOut_valid), 64'((occ > 0) ? oh : '0));
      if (occ > 0) chk("dout_data", 64'(bus.dOut), 64'(sq[0]));
      exp_rdy = (acc < c) && (occ == 0 || |(bus.dOut_ready & oh));
      chk("sin_ready", 64'(bus.sIn_ready), 64'(exp_rdy));
      if (bus.sIn_valid && bus.sIn_ready) begin
        sq.push_back(bus.sIn);
        acc++;
      end
      if (occ > 0 && |(bus.dOut_ready & oh)) begin
        void'(sq.pop_front());
        del++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    mask = '0;
    for (int i = 0; i < NREQ; i++) cnts[i] = '0;
    bus.sIn_valid  = 1'b1;
    bus.sIn        = '0;
    bus.dOut_ready = '0;
    apply_req();
    rr_m = 0; last_g = -1; grant_cyc = 0; prev_cyc = 0; data_base = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_sin_ready", 64'(bus.sIn_ready), 64'd0);
    chk("reset_dout_valid", 64'(bus.dOut_valid), 64'd0);
    chk("reset_dout", 64'(bus.dOut), 64'd0);
    chk("reset_grant_id", 64'(bus.grant_id), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    // All requesters asking for one element each.
    data_base = DW'(32'h100);
    for (int k = 0; k < 5; k++) begin
      mask = '1;
      for (int i = 0; i < NREQ; i++) cnts[i] = CW'(1);
      run_burst(1'b1, 0, 0);
      if (k > 0) chk("grant_gap", 64'(grant_cyc - prev_cyc), 64'd3);
    end

    // Single three-element burst for requester 1.
    mask = 4'b0010; cnts[1] = CW'(3); data_base = DW'(10);
    run_burst(1'b1, 0, 0);

    // Zero-length request from requester 2.
    mask = 4'b0100; cnts[2] = '0;
    run_burst(1'b0, 0, 0);
    next_cycle();
    bus.sIn_valid = 1'b1;
    apply_req();
    @(negedge clk);
    chk("zero_sin_ready", 64'(bus.sIn_ready), 64'd0);
    chk("zero_dout_valid", 64'(bus.dOut_valid), 64'd0);
    chk("zero_grant_id", 64'(bus.grant_id), 64'd2);
    chk("zero_busy", 64'(bus.busy), 64'd0);

    // Requesters 0 and 3 with rotation sitting at 3.
    mask = 4'b1001; cnts[0] = CW'(1); cnts[3] = CW'(1);
    run_burst(1'b1, 0, 0);
    chk("prio_first", 64'(last_g), 64'(EXP_T6));

    // Backpressure on the only consumer.
    mask = 4'b0001; cnts[0] = CW'(2); data_base = DW'(32'h50);
    run_burst(1'b1, 4, 0);

    // Reset mid-burst, then rotation must restart from 0.
    mask = 4'b1000; cnts[3] = CW'(5); data_base = DW'(32'h70);
    run_burst(1'b1, 0, 2);
    mask = 4'b1010; cnts[1] = CW'(1); cnts[3] = CW'(1);
    run_burst(1'b1, 0, 0);
    chk("rr_after_rst", 64'(last_g), 64'd1);

    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      nreq = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) if (nreq[i] && !mask[i]) cnts[i] = CW'($urandom);
      mask = mask | nreq;
      run_burst(1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
